// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared playfield geometry, field type, row-clear FSM state
//               encoding and the rows-cleared to score mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int ROWS    = 20;
    localparam int COLS    = 20;
    localparam int FIELD_W = ROWS * COLS;

    typedef logic [FIELD_W-1:0] field_t;

    // Explicitly encoded state values for the row-clear FSM
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_SCAN = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_SCAN = C_ST_SCAN,
        ST_DONE = C_ST_DONE
    } rc_state_t;

    // Score increment for a number of rows removed in one lock; saturates at 4+
    function automatic logic [9:0] score_for_rows(input logic [4:0] n);
        logic [9:0] v;
        case (n)
            5'd0:    v = 10'd0;
            5'd1:    v = 10'd10;
            5'd2:    v = 10'd30;
            5'd3:    v = 10'd60;
            default: v = 10'd100;
        endcase
        return v;
    endfunction

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/row_collapse.sv
`default_nettype none
// ============================================================================
// Module      : row_collapse
// Description : Combinational single-row test and collapse. Reports whether
//               row r of the working field is completely filled and provides
//               the field with row r removed (rows above move down one, a zero
//               row enters at the top).
// Ports       : work    - working field, row k at bits [COLS*k +: COLS]
//               r       - row index under examination
//               full    - row r has every bit set
//               shifted - field with row r removed
// Revision    : 1.0 - initial release
// ============================================================================
module row_collapse #(
    parameter int ROWS = 20,
    parameter int COLS = 20,
    parameter int RW   = 5
) (
    input  logic [ROWS*COLS-1:0] work,
    input  logic [RW-1:0]        r,
    output logic                 full,
    output logic [ROWS*COLS-1:0] shifted
);

    assign full = &work[r*COLS +: COLS];

    generate
        for (genvar i = 0; i < ROWS; i++) begin : g_row
            if (i == ROWS - 1) begin : g_top
                // The top row can never lie below r, so it always receives zeros
                assign shifted[i*COLS +: COLS] = '0;
            end else begin : g_body
                // Rows below r stay put; r and everything above take the row above
                assign shifted[i*COLS +: COLS] = (r > RW'(i)) ? work[i*COLS +: COLS]
                                                              : work[(i+1)*COLS +: COLS];
            end
        end
    endgenerate

endmodule : row_collapse
`default_nettype wire

// File: rtl/row_clear.sv
`default_nettype none
// ============================================================================
// Module      : row_clear
// Description : Sequential line-clear stage. Copies a locked playfield, scans
//               it bottom-up one row per clock, removes every full row and
//               presents the compacted field with rows-cleared count, score
//               increment and row_down on a one-cycle done strobe.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start         - begin processing field_in (accepted in IDLE)
//               field_in      - locked playfield, row 0 at the bottom
//               busy          - high while scanning
//               done          - one-cycle result strobe
//               field_out     - compacted field, held until next done
//               rows_cleared  - rows removed by the last operation, held
//               score_plus    - score increment of the last operation, held
//               row_down      - pulses with done when any row was removed
// Revision    : 1.0 - initial release
// ============================================================================
module row_clear
    import tetris_pkg::*;
#(
    parameter int ROWS = tetris_pkg::ROWS,
    parameter int COLS = tetris_pkg::COLS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] field_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] field_out,
    output logic [4:0]           rows_cleared,
    output logic [9:0]           score_plus,
    output logic                 row_down
);

    localparam int              RW         = $clog2(ROWS);
    localparam logic [RW-1:0]   C_LAST_ROW = RW'(ROWS - 1);

    rc_state_t              r_state;
    rc_state_t              w_state_next;
    logic [ROWS*COLS-1:0]   r_work;
    logic [RW-1:0]          r_row;
    logic [4:0]             r_cnt;
    logic                   r_done;
    logic                   r_row_down;
    logic [ROWS*COLS-1:0]   r_field_out;
    logic [4:0]             r_rows_cleared;
    logic [9:0]             r_score_plus;

    logic                   w_full;
    logic [ROWS*COLS-1:0]   w_shifted;

    row_collapse #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW)
    ) u_row_collapse (
        .work    (r_work),
        .r       (r_row),
        .full    (w_full),
        .shifted (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_SCAN;
            // A full row keeps the index; the zero row inserted at the top
            // guarantees the scan eventually reaches a non-full top row.
            ST_SCAN: if (!w_full && (r_row == C_LAST_ROW)) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work         <= '0;
            r_row          <= '0;
            r_cnt          <= '0;
            r_done         <= 1'b0;
            r_row_down     <= 1'b0;
            r_field_out    <= '0;
            r_rows_cleared <= '0;
            r_score_plus   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_row_down <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work <= field_in;
                        r_row  <= '0;
                        r_cnt  <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_full) begin
                        r_work <= w_shifted;
                        r_cnt  <= r_cnt + 5'd1;
                    end else if (r_row != C_LAST_ROW) begin
                        r_row <= r_row + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_field_out    <= r_work;
                    r_rows_cleared <= r_cnt;
                    r_score_plus   <= score_for_rows(r_cnt);
                    r_done         <= 1'b1;
                    r_row_down     <= (r_cnt != 5'd0);
                end
                default: ;
            endcase
        end
    end

    assign busy         = (r_state == ST_SCAN);
    assign done         = r_done;
    assign row_down     = r_row_down;
    assign field_out    = r_field_out;
    assign rows_cleared = r_rows_cleared;
    assign score_plus   = r_score_plus;

endmodule : row_clear
`default_nettype wire

// File: doc/row_clear.md
# row_clear

Line-clear stage that sits directly upstream of `field_display`. It takes the 400-bit playfield after a piece has locked and removes every completely filled row. Rows above each removed row collapse downward. It then presents the compacted field, a `row_down` pulse and a `score_plus` increment on a one-cycle `done` strobe; `field_display` consumes these as its `field_display_in` and score inputs. The work is sequential: one row is examined per clock, so no 400-bit-wide single-cycle compare/shift network is needed.

## Interface
- `ROWS`, 20, number of field rows.
- `COLS`, 20, number of columns; `ROWS*COLS` must equal 400.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to process `field_in`; sampled only in IDLE.
- `field_in`  in  400  locked field; row r occupies bits [COLS*r+COLS-1 : COLS*r]; row 0 is the bottom row.
- `busy`  out  1  high while in SCAN.
- `done`  out  1  one-cycle pulse; `field_out`, `rows_cleared`, `score_plus`, `row_down` are valid in this cycle.
- `field_out`  out  400  compacted field; holds its value until the next `done`.
- `rows_cleared`  out  5  number of rows removed in the last operation; held.
- `score_plus`  out  10  score increment for the last operation; held.
- `row_down`  out  1  pulses with `done` when `rows_cleared` > 0.

## Operation
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - On `start`: copy `field_in` into the working register `work`, set `r`=0 and `cnt`=0, then go to SCAN.
  - Without `start`: stay in IDLE; outputs hold.
- SCAN, one row per cycle, examining `work` row `r`:
  - Row `r` full (all COLS bits set): rows r..ROWS-2 take rows r+1..ROWS-1; row ROWS-1 is filled with zeros; `cnt`++; `r` is unchanged, so the same index is re-checked next cycle.
  - Row `r` not full and `r` < ROWS-1: `r`++.
  - Row `r` not full and `r` == ROWS-1: go to DONE.
- DONE, single cycle:
  - `field_out` ← `work`; `rows_cleared` ← `cnt`.
  - `score_plus` ← SCORE(`cnt`): 0→0, 1→10, 2→30, 3→60, 4 or more→100 (saturates).
  - `done`=1; `row_down`=(`cnt`≠0).
  - Next state is IDLE.
- Every SCAN pass terminates, because the inserted top row is always zero and therefore never full.
- `start` asserted in SCAN or DONE is ignored; it is not queued.
- `cnt` is 5 bits wide (max ROWS=20, no overflow). `score_plus` is 10 bits, max 100.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `row_down`=0, `field_out`=0, `rows_cleared`=0, `score_plus`=0, `work`=0.
- `rst` takes effect on the next edge from any state. An operation interrupted mid-SCAN is discarded and produces no `done`.
- Latency: with `start` sampled at edge T, `done` is high in the cycle after edge T+ROWS+n+1, where n is the number of rows cleared. Examples: empty field → 21 cycles; four cleared rows → 25 cycles.
- `busy` is high for exactly ROWS+n cycles. `done` and `busy` are never high together.
- `start` may be asserted in the cycle immediately after `done` (back-to-back operation).
- `field_out` changes only on the DONE edge or on reset.

## Structure
- Shared package `tetris_pkg` holds:
  - `ROWS`, `COLS`, `FIELD_W`=400
  - the `field_t` typedef (logic [399:0])
  - the state enum for this FSM
  - the `score_for_rows()` function implementing the SCORE table.
- One natural sub-module, `row_collapse`: combinational; inputs `work` and `r`; outputs `full` and the shifted field. The FSM wrapper instantiates it once.

## Test plan
- Empty field plus `start` → `done` 21 cycles later, `field_out`=0, `rows_cleared`=0, `score_plus`=0, `row_down`=0.
- Row 0 full, row 1 = 20'h00001 → `done` at 22 cycles, row 0 of `field_out` = 20'h00001, rows 1–19 zero, `rows_cleared`=1, `score_plus`=10, `row_down`=1.
- Rows 0–3 full, row 4 = 20'hAAAAA → `done` at 25 cycles, row 0 = 20'hAAAAA, `score_plus`=100, `rows_cleared`=4.
- Rows 2 and 5 full, other rows distinct patterns → the remaining rows keep their order, each shifted down by the number of cleared rows beneath it; top two rows zero; `score_plus`=30.
- All 20 rows full → `field_out`=0, `rows_cleared`=20, `score_plus`=100, `done` at 41 cycles.
- `rst` asserted 5 cycles into SCAN → next cycle `busy`=0, all outputs zero, and no `done` appears. `start` pulsed during SCAN → ignored, exactly one `done` is produced.
